// File: rtl/i2c_slave_ctrl.sv
// ============================================================================
//  Module   : i2c_slave_ctrl
//  Purpose  : I2C slave sequencing FSM (bit counter, address decision, ACK slots).
//             Optional macro I2C_GEN_CALL_EN adds the general_call input.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module i2c_slave_ctrl #(
    parameter int BYTE_BITS = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       rising_edge_found,
    input  logic       falling_edge_found,
    input  logic       start_found,
    input  logic       stop_found,
    input  logic       sda_sync,
    input  logic       address_match,
    input  logic       rw_mode,
    input  logic       tx_fifo_empty,
`ifdef I2C_GEN_CALL_EN
    input  logic       general_call,
`endif
    output logic       rx_enable,
    output logic       tx_enable,
    output logic       load_data,
    output logic       read_enable,
    output logic [1:0] sda_mode,
    output logic       rx_byte_done,
    output logic       tx_underrun,
    output logic       busy
);

    localparam int                   C_CNT_W    = $clog2(BYTE_BITS + 1);
    localparam logic [C_CNT_W-1:0]   C_CNT_FULL = C_CNT_W'(BYTE_BITS);
    localparam logic [C_CNT_W-1:0]   C_CNT_ONE  = C_CNT_W'(1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_ADDR      = 4'd1,
        S_ADDR_CHK  = 4'd2,
        S_ACK_ADDR  = 4'd3,
        S_LOAD      = 4'd4,
        S_TX        = 4'd5,
        S_MACK      = 4'd6,
        S_RX        = 4'd7,
        S_ACK_DATA  = 4'd8,
        S_WAIT_STOP = 4'd9
    } state_t;

    state_t               state_q, state_d;
    logic [C_CNT_W-1:0]   cnt_q, cnt_d;
    logic                 ack_q, ack_d;
    logic                 underrun_q, underrun_d;
    logic                 rx_done_q, rx_done_d;

    logic w_cnt_full;
    logic w_match;
    logic w_read;

    assign w_cnt_full = (cnt_q == C_CNT_FULL);

`ifdef I2C_GEN_CALL_EN
    // A general call is always a write, whatever the R/W bit decodes to.
    assign w_match = address_match | general_call;
    assign w_read  = rw_mode & ~general_call;
`else
    assign w_match = address_match;
    assign w_read  = rw_mode;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ack_q      <= 1'b1;
            underrun_q <= 1'b0;
            rx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ack_q      <= ack_d;
            underrun_q <= underrun_d;
            rx_done_q  <= rx_done_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ack_d      = ack_q;
        underrun_d = underrun_q;
        rx_done_d  = 1'b0;
        rx_enable  = 1'b0;
        tx_enable  = 1'b0;

        // Bus conditions override every edge pulse seen in the same cycle.
        if (stop_found) begin
            state_d = S_IDLE;
        end else if (start_found) begin
            state_d = S_ADDR;
        end else begin
            case (state_q)
                S_ADDR: begin
                    rx_enable = rising_edge_found;
                    if (falling_edge_found && w_cnt_full) state_d = S_ADDR_CHK;
                end
                S_ADDR_CHK: state_d = w_match ? S_ACK_ADDR : S_WAIT_STOP;
                S_ACK_ADDR: begin
                    if (falling_edge_found) state_d = w_read ? S_LOAD : S_RX;
                end
                S_LOAD: begin
                    underrun_d = tx_fifo_empty;
                    state_d    = S_TX;
                end
                S_TX: begin
                    tx_enable = falling_edge_found && (cnt_q != '0) && !w_cnt_full;
                    if (falling_edge_found && w_cnt_full) state_d = S_MACK;
                end
                S_MACK: begin
                    if (rising_edge_found) ack_d = sda_sync;
                    if (falling_edge_found) state_d = ack_q ? S_WAIT_STOP : S_LOAD;
                end
                S_RX: begin
                    rx_enable = rising_edge_found;
                    if (falling_edge_found && w_cnt_full) begin
                        state_d   = S_ACK_DATA;
                        rx_done_d = 1'b1;
                    end
                end
                S_ACK_DATA: begin
                    if (falling_edge_found) state_d = S_RX;
                end
                default: ;
            endcase
        end

        // A repeated START re-enters ADDR without a state change, so it clears too.
        if ((state_d != state_q) || start_found) begin
            cnt_d = '0;
        end else if (rising_edge_found && !w_cnt_full &&
                     ((state_q == S_ADDR) || (state_q == S_RX) || (state_q == S_TX))) begin
            cnt_d = cnt_q + C_CNT_ONE;
        end
    end

    always_comb begin
        load_data   = (state_q == S_LOAD) && !tx_fifo_empty;
        read_enable = (state_q == S_LOAD) && !tx_fifo_empty;
        tx_underrun = (state_q == S_LOAD) && tx_fifo_empty;
        busy        = (state_q != S_IDLE);
        case (state_q)
            S_ACK_ADDR, S_ACK_DATA: sda_mode = 2'b01;
            S_TX:                   sda_mode = underrun_q ? 2'b10 : 2'b11;
            default:                sda_mode = 2'b00;
        endcase
    end

    assign rx_byte_done = rx_done_q;

endmodule

`default_nettype wire
